// File: rtl/card_match_pkg.sv
// Shared types and geometry constants for the card-corner rank matching path.
package card_match_pkg;

    // Corner window geometry in pixels.
    localparam int unsigned CORNER_WIDTH = 28;
    localparam int unsigned RANK_HEIGHT  = 40;
    localparam int unsigned SUIT_HEIGHT  = 36;
    localparam int unsigned RANK_SIZE    = CORNER_WIDTH * RANK_HEIGHT;

    // Wide enough for any mismatch count over the rank window.
    localparam int unsigned SCORE_W = $clog2(RANK_SIZE);

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCompare,
        StReport
    } state_e;

    // Rank template order as stored in the engine kernel ROM.
    typedef enum logic [3:0] {
        RANK_A  = 4'd0,
        RANK_2  = 4'd1,
        RANK_3  = 4'd2,
        RANK_4  = 4'd3,
        RANK_5  = 4'd4,
        RANK_6  = 4'd5,
        RANK_7  = 4'd6,
        RANK_8  = 4'd7,
        RANK_9  = 4'd8,
        RANK_10 = 4'd9,
        RANK_J  = 4'd10,
        RANK_Q  = 4'd11,
        RANK_K  = 4'd12
    } rank_e;

endpackage

// File: rtl/min_score_tracker.sv
// Running minimum of per-kernel scores; on a tie the earlier (lower) index is kept.
module min_score_tracker
    import card_match_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               valid,
    input  logic [SCORE_W-1:0] score,
    input  logic [IDX_W-1:0]   index,
    output logic [SCORE_W-1:0] run_min,
    output logic [IDX_W-1:0]   run_idx
);

    logic [SCORE_W-1:0] min_q, min_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // Strict-less update so an all-ones (timed-out) score never displaces a real one.
    always_comb begin
        min_d = min_q;
        idx_d = idx_q;
        if (clear) begin
            min_d = '1;
            idx_d = '0;
        end else if (valid && (score < min_q)) begin
            min_d = score;
            idx_d = index;
        end
    end

    // Minimum and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '1;
            idx_q <= '0;
        end else begin
            min_q <= min_d;
            idx_q <= idx_d;
        end
    end

    assign run_min = min_q;
    assign run_idx = idx_q;

endmodule

// File: rtl/rank_match_scheduler.sv
// Time-shares one template-scoring engine across all rank kernels after each
// corner capture and reports the lowest-mismatch rank.
module rank_match_scheduler
    import card_match_pkg::*;
#(
    parameter int unsigned NUM_KERNELS  = 13,
    parameter int unsigned MATCH_THRESH = 300,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           capture_done,
    output logic                           eng_start,
    output logic [$clog2(NUM_KERNELS)-1:0] eng_kernel_sel,
    input  logic                           eng_done,
    input  logic [SCORE_W-1:0]             eng_score,
    output logic                           busy,
    output logic                           result_valid,
    output logic [$clog2(NUM_KERNELS)-1:0] best_rank,
    output logic [SCORE_W-1:0]             best_score,
    output logic                           no_match,
    output logic                           timeout_err,
    output logic                           overrun
);

    localparam int unsigned KW = $clog2(NUM_KERNELS);
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [KW-1:0]      LAST_K       = KW'(NUM_KERNELS - 1);
    localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] THRESH       = SCORE_W'(MATCH_THRESH);

    state_e state_q, state_d;

    logic [KW-1:0]      k_q, k_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               timeout_err_q, timeout_err_d;
    logic               overrun_q, overrun_d;
    logic [KW-1:0]      best_rank_q, best_rank_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic               no_match_q, no_match_d;
    logic               result_valid_q, result_valid_d;

    logic               trk_clear;
    logic               trk_valid;
    logic [SCORE_W-1:0] trk_min;
    logic [KW-1:0]      trk_idx;

    min_score_tracker #(
        .IDX_W(KW)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (trk_clear),
        .valid   (trk_valid),
        .score   (score_q),
        .index   (k_q),
        .run_min (trk_min),
        .run_idx (trk_idx)
    );

    // Next-state and datapath updates for the kernel sequencing FSM.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        cnt_d          = cnt_q;
        score_d        = score_q;
        timeout_err_d  = timeout_err_q;
        overrun_d      = overrun_q;
        best_rank_d    = best_rank_q;
        best_score_d   = best_score_q;
        no_match_d     = no_match_q;
        result_valid_d = 1'b0;
        trk_clear      = 1'b0;
        trk_valid      = 1'b0;

        // Any capture outside IDLE (including the REPORT cycle) is dropped and flagged.
        if (capture_done && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (capture_done) begin
                    k_d           = '0;
                    trk_clear     = 1'b1;
                    timeout_err_d = 1'b0;
                    overrun_d     = 1'b0;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (eng_done) begin
                    score_d = eng_score;
                    state_d = StCompare;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // A silent engine scores worst-case so the kernel cannot win.
                    score_d       = '1;
                    timeout_err_d = 1'b1;
                    state_d       = StCompare;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCompare: begin
                trk_valid = 1'b1;
                if (k_q == LAST_K) begin
                    state_d = StReport;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StIssue;
                end
            end
            StReport: begin
                best_rank_d    = trk_idx;
                best_score_d   = trk_min;
                no_match_d     = (trk_min > THRESH);
                result_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset abandons any run in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            cnt_q          <= '0;
            score_q        <= '1;
            timeout_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
            best_rank_q    <= KW'(RANK_A);
            best_score_q   <= '1;
            no_match_q     <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            cnt_q          <= cnt_d;
            score_q        <= score_d;
            timeout_err_q  <= timeout_err_d;
            overrun_q      <= overrun_d;
            best_rank_q    <= best_rank_d;
            best_score_q   <= best_score_d;
            no_match_q     <= no_match_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign eng_start      = (state_q == StIssue);
    assign eng_kernel_sel = k_q;
    assign busy           = (state_q != StIdle);
    assign result_valid   = result_valid_q;
    assign best_rank      = best_rank_q;
    assign best_score     = best_score_q;
    assign no_match       = no_match_q;
    assign timeout_err    = timeout_err_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_rank_match_scheduler.sv
// Directed bench for rank_match_scheduler with a fixed-latency engine model.
module tb_rank_match_scheduler;

    localparam int NK  = 13;
    localparam int D   = 5;
    localparam int LAT = 1 + NK * (D + 2) + 1;
    localparam int TO  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_done;
    logic        eng_start;
    logic [3:0]  eng_kernel_sel;
    logic        eng_done;
    logic [10:0] eng_score;
    logic        busy;
    logic        result_valid;
    logic [3:0]  best_rank;
    logic [10:0] best_score;
    logic        no_match;
    logic        timeout_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [10:0] scores [NK];
    int          skip_k   = -1;
    int          pend     = 0;
    int          cur      = 0;
    int          start_q[$];
    int          rv_count = 0;

    rank_match_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .capture_done   (capture_done),
        .eng_start      (eng_start),
        .eng_kernel_sel (eng_kernel_sel),
        .eng_done       (eng_done),
        .eng_score      (eng_score),
        .busy           (busy),
        .result_valid   (result_valid),
        .best_rank      (best_rank),
        .best_score     (best_score),
        .no_match       (no_match),
        .timeout_err    (timeout_err),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Engine model: answers D cycles after eng_start, or never for skip_k.
    initial begin
        eng_done  = 1'b0;
        eng_score = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    eng_done  = 1'b1;
                    eng_score = scores[cur];
                end
            end
            if (!rst && eng_start) begin
                cur  = int'(eng_kernel_sel);
                pend = (cur == skip_k) ? 0 : D;
            end
        end
    end

    // Monitor: records issued kernels and counts result pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_start) start_q.push_back(int'(eng_kernel_sel));
            if (result_valid) rv_count++;
        end
    end

    task automatic set_scores(input int v);
        for (int i = 0; i < NK; i++) scores[i] = 11'(v);
        skip_k = -1;
        start_q.delete();
        rv_count = 0;
    endtask

    task automatic pulse_capture(output int c0);
        @(negedge clk);
        capture_done = 1'b1;
        c0 = cyc;
        @(negedge clk);
        capture_done = 1'b0;
    endtask

    task automatic wait_result(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (result_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({eng_start, eng_kernel_sel, busy, result_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {eng_start, eng_kernel_sel, busy, result_valid});
        end
        checks++;
        if (best_rank !== 4'd0 || best_score !== 11'h7ff || no_match !== 1'b1) begin
            errors++;
            $display("FAIL reset_result: got %0d/%0d/%b expected 0/2047/1", best_rank, best_score, no_match);
        end
        checks++;
        if (timeout_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b%b expected 00", timeout_err, overrun);
        end
    endtask

    task automatic test_basic;
        int c0;
        bit got;
        bit seq_ok;
        set_scores(700);
        scores[0] = 11'd900;
        scores[1] = 11'd850;
        scores[2] = 11'd40;
        pulse_capture(c0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_result(LAT + 20, got);
        checks++;
        if (!got) begin errors++; $display("FAIL basic_done: got no result_valid expected one"); end
        checks++;
        if (cyc - c0 != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc - c0, LAT); end
        checks++;
        if (best_rank !== 4'd2 || best_score !== 11'd40 || no_match !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d/%0d/%b expected 2/40/0", best_rank, best_score, no_match);
        end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got busy=%b to=%b expected 0 0", busy, timeout_err);
        end
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || rv_count != 1 || best_rank !== 4'd2) begin
            errors++;
            $display("FAIL basic_pulse: got rv=%b cnt=%0d rank=%0d expected 0 1 2", result_valid, rv_count, best_rank);
        end
        seq_ok = (start_q.size() == NK);
        for (int i = 0; i < start_q.size(); i++) if (start_q[i] != i) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin errors++; $display("FAIL basic_starts: got %0d pulses expected 13 in order 0..12", start_q.size()); end
    endtask

    task automatic test_tie;
        int c0;
        bit got;
        set_scores(500);
        scores[3] = 11'd120;
        scores[9] = 11'd120;
        pulse_capture(c0);
        wait_result(LAT + 20, got);
        checks++;
        if (!got || best_rank !== 4'd3 || best_score !== 11'd120 || no_match !== 1'b0) begin
            errors++;
            $display("FAIL tie_result: got %b %0d/%0d/%b expected 1 3/120/0", got, best_rank, best_score, no_match);
        end
    endtask

    task automatic test_no_match;
        int c0;
        bit got;
        set_scores(400);
        pulse_capture(c0);
        wait_result(LAT + 20, got);
        checks++;
        if (!got || best_rank !== 4'd0 || best_score !== 11'd400 || no_match !== 1'b1) begin
            errors++;
            $display("FAIL nomatch_result: got %b %0d/%0d/%b expected 1 0/400/1", got, best_rank, best_score, no_match);
        end
    endtask

    task automatic test_timeout;
        int c0;
        bit got;
        bit seq_ok;
        set_scores(200);
        scores[7] = 11'd50;
        skip_k = 5;
        pulse_capture(c0);
        wait_result(LAT + TO + 20, got);
        checks++;
        if (!got || cyc - c0 != LAT + TO - D) begin
            errors++;
            $display("FAIL timeout_latency: got %b %0d expected 1 %0d", got, cyc - c0, LAT + TO - D);
        end
        checks++;
        if (timeout_err !== 1'b1 || best_rank !== 4'd7 || best_score !== 11'd50 || no_match !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result: got %b %0d/%0d/%b expected 1 7/50/0", timeout_err, best_rank, best_score, no_match);
        end
        seq_ok = (start_q.size() == NK);
        for (int i = 0; i < start_q.size(); i++) if (start_q[i] != i) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin errors++; $display("FAIL timeout_starts: got %0d pulses expected 13 in order", start_q.size()); end
    endtask

    task automatic test_overrun_back_to_back;
        int c0;
        int c1;
        bit got;
        set_scores(700);
        scores[2] = 11'd40;
        pulse_capture(c0);
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL ovr_to_clear: got %b expected 0", timeout_err); end
        repeat (9) @(negedge clk);
        capture_done = 1'b1;
        @(negedge clk);
        capture_done = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set: got ovr=%b busy=%b expected 1 1", overrun, busy);
        end
        wait_result(LAT + 20, got);
        checks++;
        if (!got || cyc - c0 != LAT || best_rank !== 4'd2 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_run: got %b lat=%0d rank=%0d ovr=%b expected 1 93 2 1", got, cyc - c0, best_rank, overrun);
        end
        // Capture in the cycle right after result_valid must be accepted.
        scores[2] = 11'd700;
        scores[11] = 11'd33;
        capture_done = 1'b1;
        c1 = cyc;
        @(negedge clk);
        capture_done = 1'b0;
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1 || rv_count != 1) begin
            errors++;
            $display("FAIL b2b_accept: got ovr=%b busy=%b rv=%0d expected 0 1 1", overrun, busy, rv_count);
        end
        wait_result(LAT + 20, got);
        checks++;
        if (!got || cyc - c1 != LAT || best_rank !== 4'd11 || best_score !== 11'd33) begin
            errors++;
            $display("FAIL b2b_result: got %b lat=%0d %0d/%0d expected 1 93 11/33", got, cyc - c1, best_rank, best_score);
        end
    endtask

    task automatic test_report_collision;
        int c0;
        set_scores(600);
        scores[4] = 11'd77;
        pulse_capture(c0);
        repeat (LAT - 2) @(negedge clk);
        capture_done = 1'b1;
        @(negedge clk);
        capture_done = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || overrun !== 1'b1 || best_rank !== 4'd4) begin
            errors++;
            $display("FAIL report_cap: got rv=%b ovr=%b rank=%0d expected 1 1 4", result_valid, overrun, best_rank);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rv_count != 1 || start_q.size() != NK) begin
            errors++;
            $display("FAIL report_ignored: got busy=%b rv=%0d starts=%0d expected 0 1 13", busy, rv_count, start_q.size());
        end
    endtask

    task automatic test_reset_mid_run;
        int c0;
        bit got;
        set_scores(700);
        scores[2] = 11'd40;
        pulse_capture(c0);
        // Kernel 6 is issued at c0+43 and waits through c0+48.
        repeat (44) @(negedge clk);
        checks++;
        if (eng_kernel_sel !== 4'd6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pos: got sel=%0d busy=%b expected 6 1", eng_kernel_sel, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({eng_start, eng_kernel_sel, busy, result_valid, timeout_err, overrun} !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b expected 0", {eng_start, eng_kernel_sel, busy, result_valid, timeout_err, overrun});
        end
        checks++;
        if (best_rank !== 4'd0 || best_score !== 11'h7ff || no_match !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_result: got %0d/%0d/%b expected 0/2047/1", best_rank, best_score, no_match);
        end
        repeat (LAT) @(negedge clk);
        checks++;
        if (rv_count != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_norv: got rv=%0d busy=%b expected 0 0", rv_count, busy);
        end
        start_q.delete();
        pulse_capture(c0);
        wait_result(LAT + 20, got);
        checks++;
        if (!got || cyc - c0 != LAT || best_rank !== 4'd2 || start_q.size() != NK || start_q[0] != 0) begin
            errors++;
            $display("FAIL rstmid_restart: got %b lat=%0d rank=%0d starts=%0d expected 1 93 2 13", got, cyc - c0, best_rank, start_q.size());
        end
    endtask

    initial begin
        rst          = 1'b1;
        capture_done = 1'b0;
        set_scores(0);
        test_reset;
        test_basic;
        test_tie;
        test_no_match;
        test_timeout;
        test_overrun_back_to_back;
        test_report_collision;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rank_match_scheduler.md
Name: rank_match_scheduler

Overview:
- Sequences one shared XOR template-scoring engine across all rank kernels (A,2..10,J,Q,K) after each card-corner capture.
- Issues one scoring pass per kernel, collects each mismatch score, tracks the minimum, and reports the winning rank index and score.
- Sits between the corner-capture/bounding-box logic (trigger source) and the rank classifier/display logic (result sink).

Parameters:
- NUM_KERNELS, 13, number of rank templates to sequence; kernel index range 0..NUM_KERNELS-1.
- CORNER_WIDTH, 28, corner window width in pixels.
- RANK_HEIGHT, 40, rank window height in pixels.
- SCORE_W, $clog2(CORNER_WIDTH*RANK_HEIGHT) = 11, score width.
- MATCH_THRESH, 300, a best score strictly greater than this is reported as no-match.
- TIMEOUT, 4096, maximum cycles to wait for eng_done per kernel.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- capture_done  in  1  one-cycle pulse: the corner mask for a new card is stored in the engine buffer.
- eng_start  out  1  one-cycle pulse: begin a scoring pass with eng_kernel_sel.
- eng_kernel_sel  out  $clog2(NUM_KERNELS)  kernel index for the engine; held stable from eng_start until eng_done.
- eng_done  in  1  one-cycle pulse: eng_score is valid this cycle.
- eng_score  in  SCORE_W  mismatch count for the current kernel.
- busy  out  1  high from acceptance of capture_done until result_valid.
- result_valid  out  1  one-cycle pulse: result outputs updated.
- best_rank  out  $clog2(NUM_KERNELS)  index of the minimum-score kernel; held until the next result.
- best_score  out  SCORE_W  the minimum score; held until the next result.
- no_match  out  1  best_score > MATCH_THRESH; held with the result.
- timeout_err  out  1  sticky; at least one kernel timed out in the last run; cleared on the next accepted capture_done.
- overrun  out  1  sticky; capture_done arrived while busy; cleared on the next accepted capture_done.

Behaviour:
- Reset values: eng_start=0, eng_kernel_sel=0, busy=0, result_valid=0, best_rank=0, best_score all-ones, no_match=1, timeout_err=0, overrun=0.
- Reset asserted mid-run aborts the run immediately and returns to IDLE; no result_valid is produced.
- States: IDLE, ISSUE, WAIT, COMPARE, REPORT.
- IDLE: on capture_done, set busy, set k=0, set run_min to all-ones, clear timeout_err and overrun, then go to ISSUE.
- ISSUE: drive eng_kernel_sel=k and pulse eng_start for exactly 1 cycle; clear the timeout counter; go to WAIT.
- WAIT: on eng_done, latch eng_score and go to COMPARE.
  - If the counter reaches TIMEOUT-1 without eng_done, latch all-ones as the score, set timeout_err, and go to COMPARE.
  - An eng_done arriving in any state other than WAIT is ignored.
- COMPARE: if score < run_min (strict), update run_min and run_idx=k; ties keep the lower index.
  - If k==NUM_KERNELS-1, go to REPORT; otherwise k++ and go to ISSUE.
- REPORT: in one cycle, write best_rank, best_score and no_match; pulse result_valid; clear busy; go to IDLE.
- Latency from capture_done to result_valid: sum over kernels of (engine latency + 2), plus 2 cycles.
  - With an engine that always completes D cycles after eng_start: 1 + NUM_KERNELS*(D+2) + 1.
- capture_done while busy: ignored, overrun set; the run in progress is unaffected.
- capture_done in the same cycle as REPORT: ignored, overrun set.
- A capture_done in the cycle after result_valid (state IDLE) is accepted normally.
- Scores are compared unsigned at SCORE_W width; all-ones never wins against a real score.
  - If every kernel times out, the result is best_rank=0, best_score=all-ones, no_match=1.

Decomposition:
- Shared package card_match_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, COMPARE, REPORT);
  - constants CORNER_WIDTH, RANK_HEIGHT, SUIT_HEIGHT, RANK_SIZE, SCORE_W;
  - the rank index enum (RANK_A=0 … RANK_K=12).
- One sub-module, min_score_tracker: holds run_min/run_idx, with clear, valid, score and index inputs; implements strict-less compare with low-index tie-break.

Test Plan:
- Engine model with D=5 returning scores [900,850,40,…(all 700)]: one capture_done gives result_valid after 1+13*7+1=93 cycles, best_rank=2, best_score=40, no_match=0, with 13 eng_start pulses at kernel_sel 0..12.
- Scores kernel3=120 and kernel9=120, all others 500: best_rank=3, best_score=120.
- All scores 400 (>300): best_rank=0, best_score=400, no_match=1.
- Engine never answers kernel 5, others 200 except kernel 7=50: timeout after 4096 cycles, timeout_err=1, best_rank=7; eng_kernel_sel advances to 6 after the timeout.
- capture_done pulsed at cycle 10 of a run: overrun=1, exactly one result_valid, and overrun clears on the next accepted capture_done.
- rst asserted during WAIT of kernel 6: all outputs return to reset values next cycle, no result_valid; a fresh capture_done restarts from kernel 0.
